sdf_ms_out_demux: RTL and testbench

//  Downstream stage of a multi-stream SDF actor. Consumes the actor's single

---
 rtl/sdf_ms_out_demux.sv | 99 +++++++++
 tb/tb_sdf_ms_out_demux.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/sdf_ms_out_demux.sv
// Output demultiplexer for a multi-stream SDF actor: steers accepted tokens round-robin,
// TOKENS at a time, into FLUX private show-ahead FIFOs that are read independently.
module sdf_ms_out_demux #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned FLUX   = 2,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned TOKENS = 1
) (
   input  logic                     ck,
   input  logic                     rst,
   input  logic                     in_wr,
   input  logic [WIDTH-1:0]         in_data,
   output logic                     in_full,
   input  logic [FLUX-1:0]          out_rd,
   output logic [FLUX-1:0]          out_empty,
   output logic [FLUX*WIDTH-1:0]    out_data,
   output logic [$clog2(FLUX)-1:0]  cur_flux
);

   localparam int unsigned FW = $clog2(FLUX);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned TW = (TOKENS > 1) ? $clog2(TOKENS) : 1;

   logic [WIDTH-1:0] r_mem     [FLUX][DEPTH];
   logic [AW-1:0]    r_wr_ptr  [FLUX];
   logic [AW-1:0]    r_rd_ptr  [FLUX];
   logic [CW-1:0]    r_cnt     [FLUX];
   logic [FW-1:0]    r_cur_flux;
   logic [TW-1:0]    r_tok_cnt;

   logic             w_wr_acc;
   logic [FLUX-1:0]  w_full;
   logic [FLUX-1:0]  w_wr_f;
   logic [FLUX-1:0]  w_rd_f;

   // Flags come from registered counts only, so there is no rd->full combinational path.
   always_comb begin
      w_full    = '0;
      out_empty = '0;
      out_data  = '0;
      for (int f = 0; f < FLUX; f++) begin
         w_full[f]                     = (r_cnt[f] == CW'(DEPTH));
         out_empty[f]                  = (r_cnt[f] == '0);
         out_data[f*WIDTH +: WIDTH]    = r_mem[f][r_rd_ptr[f]];
      end
   end

   assign in_full  = w_full[r_cur_flux];
   assign w_wr_acc = in_wr && !in_full;
   assign cur_flux = r_cur_flux;

   always_comb begin
      w_wr_f = '0;
      w_rd_f = '0;
      for (int f = 0; f < FLUX; f++) begin
         w_wr_f[f] = w_wr_acc && (r_cur_flux == FW'(f));
         w_rd_f[f] = out_rd[f] && !out_empty[f];
      end
   end

   always_ff @(posedge ck) begin
      if (rst) begin
         r_cur_flux <= '0;
         r_tok_cnt  <= '0;
         for (int f = 0; f < FLUX; f++) begin
            r_wr_ptr[f] <= '0;
            r_rd_ptr[f] <= '0;
            r_cnt[f]    <= '0;
         end
      end else begin
         for (int f = 0; f < FLUX; f++) begin
            if (w_wr_f[f]) r_wr_ptr[f] <= r_wr_ptr[f] + AW'(1);
            if (w_rd_f[f]) r_rd_ptr[f] <= r_rd_ptr[f] + AW'(1);
            case ({w_wr_f[f], w_rd_f[f]})
               2'b10:   r_cnt[f] <= r_cnt[f] + CW'(1);
               2'b01:   r_cnt[f] <= r_cnt[f] - CW'(1);
               default: r_cnt[f] <= r_cnt[f];
            endcase
         end
         if (w_wr_acc) begin
            if (r_tok_cnt == TW'(TOKENS - 1)) begin
               r_tok_cnt  <= '0;
               r_cur_flux <= (r_cur_flux == FW'(FLUX - 1)) ? '0 : r_cur_flux + FW'(1);
            end else begin
               r_tok_cnt  <= r_tok_cnt + TW'(1);
            end
         end
      end
   end

   // Storage is intentionally not reset; empty flags mask stale contents.
   always_ff @(posedge ck) begin
      if (w_wr_acc) begin
         r_mem[r_cur_flux][r_wr_ptr[r_cur_flux]] <= in_data;
      end
   end

endmodule

// File: tb/tb_sdf_ms_out_demux.sv
// Directed bench: a vector table on a TOKENS=1 instance plus hand-written stream
// and mid-stream reset sequences on a TOKENS=3 instance.
module tb_sdf_ms_out_demux;

   logic ck = 1'b0;
   always #5 ck = ~ck;

   // TOKENS=1 instance
   logic        a_rst, a_wr, a_full, a_cur;
   logic [7:0]  a_din;
   logic [1:0]  a_rd, a_empty;
   logic [15:0] a_dout;

   // TOKENS=3 instance
   logic        b_rst, b_wr, b_full, b_cur;
   logic [7:0]  b_din;
   logic [1:0]  b_rd, b_empty;
   logic [15:0] b_dout;

   sdf_ms_out_demux #(.WIDTH(8), .FLUX(2), .DEPTH(4), .TOKENS(1)) u_dut1 (
      .ck(ck), .rst(a_rst), .in_wr(a_wr), .in_data(a_din), .in_full(a_full),
      .out_rd(a_rd), .out_empty(a_empty), .out_data(a_dout), .cur_flux(a_cur)
   );

   sdf_ms_out_demux #(.WIDTH(8), .FLUX(2), .DEPTH(4), .TOKENS(3)) u_dut3 (
      .ck(ck), .rst(b_rst), .in_wr(b_wr), .in_data(b_din), .in_full(b_full),
      .out_rd(b_rd), .out_empty(b_empty), .out_data(b_dout), .cur_flux(b_cur)
   );

   typedef struct {
      logic       rst;
      logic       wr;
      logic [7:0] din;
      logic [1:0] rd;
      logic       exp_full;
      logic [1:0] exp_empty;
      logic       exp_cur;
      logic [7:0] exp_d0;
      logic [7:0] exp_d1;
   } vec_t;

   vec_t vecs[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic add(input logic r, input logic w, input logic [7:0] d, input logic [1:0] rd,
                      input logic f, input logic [1:0] e, input logic c,
                      input logic [7:0] d0, input logic [7:0] d1);
      vec_t v;
      v.rst = r; v.wr = w; v.din = d; v.rd = rd;
      v.exp_full = f; v.exp_empty = e; v.exp_cur = c; v.exp_d0 = d0; v.exp_d1 = d1;
      vecs.push_back(v);
   endtask

   initial begin
      int q0[$];
      int q1[$];
      int nxt, popped, cyc, m_cur, m_tok;
      bit acc;

      a_rst = 1'b0; a_wr = 1'b0; a_din = '0; a_rd = '0;
      b_rst = 1'b1; b_wr = 1'b0; b_din = '0; b_rd = '0;

      //   rst  wr  din    rd     full e      cur d0     d1
      add(1, 1, 8'hFF, 2'b00, 0, 2'b11, 0, 8'h00, 8'h00);
      add(1, 1, 8'hFF, 2'b00, 0, 2'b11, 0, 8'h00, 8'h00);
      add(0, 1, 8'hA0, 2'b00, 0, 2'b10, 1, 8'hA0, 8'h00);
      add(0, 1, 8'hB0, 2'b00, 0, 2'b00, 0, 8'hA0, 8'hB0);
      add(0, 1, 8'hA1, 2'b00, 0, 2'b00, 1, 8'hA0, 8'hB0);
      add(0, 1, 8'hB1, 2'b00, 0, 2'b00, 0, 8'hA0, 8'hB0);
      add(0, 0, 8'h00, 2'b01, 0, 2'b00, 0, 8'hA1, 8'hB0);
      add(0, 0, 8'h00, 2'b11, 0, 2'b01, 0, 8'h00, 8'hB1);
      add(0, 0, 8'h00, 2'b10, 0, 2'b11, 0, 8'h00, 8'h00);
      // fill both fluxes
      add(0, 1, 8'h10, 2'b00, 0, 2'b10, 1, 8'h10, 8'h00);
      add(0, 1, 8'h11, 2'b00, 0, 2'b00, 0, 8'h10, 8'h11);
      add(0, 1, 8'h12, 2'b00, 0, 2'b00, 1, 8'h10, 8'h11);
      add(0, 1, 8'h13, 2'b00, 0, 2'b00, 0, 8'h10, 8'h11);
      add(0, 1, 8'h14, 2'b00, 0, 2'b00, 1, 8'h10, 8'h11);
      add(0, 1, 8'h15, 2'b00, 0, 2'b00, 0, 8'h10, 8'h11);
      add(0, 1, 8'h16, 2'b00, 0, 2'b00, 1, 8'h10, 8'h11);
      add(0, 1, 8'h17, 2'b00, 1, 2'b00, 0, 8'h10, 8'h11);
      add(0, 1, 8'h18, 2'b00, 1, 2'b00, 0, 8'h10, 8'h11);
      // rd+wr on full flux0: write rejected, read done
      add(0, 1, 8'h18, 2'b01, 0, 2'b00, 0, 8'h12, 8'h11);
      add(0, 1, 8'h18, 2'b00, 1, 2'b00, 1, 8'h12, 8'h11);
      // drain flux1, then rd+wr on empty flux1
      add(0, 0, 8'h00, 2'b10, 0, 2'b00, 1, 8'h12, 8'h13);
      add(0, 0, 8'h00, 2'b10, 0, 2'b00, 1, 8'h12, 8'h15);
      add(0, 0, 8'h00, 2'b10, 0, 2'b00, 1, 8'h12, 8'h17);
      add(0, 0, 8'h00, 2'b10, 0, 2'b10, 1, 8'h12, 8'h00);
      add(0, 1, 8'h5A, 2'b10, 1, 2'b00, 0, 8'h12, 8'h5A);
      add(0, 0, 8'h00, 2'b10, 1, 2'b10, 0, 8'h12, 8'h00);
      add(0, 0, 8'h00, 2'b10, 1, 2'b10, 0, 8'h12, 8'h00);
      // reset wins over same-cycle rd/wr
      add(1, 1, 8'hEE, 2'b11, 0, 2'b11, 0, 8'h00, 8'h00);
      add(0, 1, 8'hC0, 2'b00, 0, 2'b10, 1, 8'hC0, 8'h00);

      for (int i = 0; i < vecs.size(); i++) begin
         a_rst = vecs[i].rst; a_wr = vecs[i].wr; a_din = vecs[i].din; a_rd = vecs[i].rd;
         @(negedge ck);
         check($sformatf("vec%0d_full", i), 32'(a_full), 32'(vecs[i].exp_full));
         check($sformatf("vec%0d_empty", i), 32'(a_empty), 32'(vecs[i].exp_empty));
         check($sformatf("vec%0d_cur", i), 32'(a_cur), 32'(vecs[i].exp_cur));
         if (!vecs[i].exp_empty[0])
            check($sformatf("vec%0d_d0", i), 32'(a_dout[7:0]), 32'(vecs[i].exp_d0));
         if (!vecs[i].exp_empty[1])
            check($sformatf("vec%0d_d1", i), 32'(a_dout[15:8]), 32'(vecs[i].exp_d1));
      end
      a_rst = 1'b0; a_wr = 1'b0; a_rd = '0;

      // Stream 0..23 through TOKENS=3 with continuous reads.
      @(negedge ck);
      b_rst = 1'b0;
      nxt = 0; popped = 0; cyc = 0; m_cur = 0; m_tok = 0;
      while (popped < 24 && cyc < 200) begin
         b_wr  = (nxt < 24);
         b_din = 8'(nxt);
         b_rd  = 2'b11;
         #1;
         check($sformatf("stream_cur_c%0d", cyc), 32'(b_cur), 32'(m_cur));
         if (!b_empty[0]) begin
            if (q0.size() == 0) check("stream_f0_unexpected", 32'(b_dout[7:0]), 32'hFFFF);
            else check($sformatf("stream_f0_tok%0d", q0[0]), 32'(b_dout[7:0]),
                       32'(q0.pop_front()));
            popped++;
         end
         if (!b_empty[1]) begin
            if (q1.size() == 0) check("stream_f1_unexpected", 32'(b_dout[15:8]), 32'hFFFF);
            else check($sformatf("stream_f1_tok%0d", q1[0]), 32'(b_dout[15:8]),
                       32'(q1.pop_front()));
            popped++;
         end
         acc = b_wr && !b_full;
         if (acc) begin
            if (((nxt / 3) % 2) == 0) q0.push_back(nxt);
            else q1.push_back(nxt);
            if (m_tok == 2) begin
               m_tok = 0;
               m_cur = 1 - m_cur;
            end else m_tok++;
            nxt++;
         end
         @(negedge ck);
         cyc++;
      end
      check("stream_all_popped", 32'(popped), 32'd24);
      b_wr = 1'b0;
      b_rd = 2'b11;
      repeat (3) @(negedge ck);
      check("stream_no_underflow", 32'(b_empty), 32'b11);
      b_rd = 2'b00;

      // Mid-stream reset after 5 writes.
      for (int k = 0; k < 5; k++) begin
         b_wr = 1'b1; b_din = 8'(k);
         @(negedge ck);
      end
      check("mid_pre_cur", 32'(b_cur), 32'd1);
      b_wr = 1'b0; b_rst = 1'b1;
      @(negedge ck);
      b_rst = 1'b0;
      check("mid_rst_empty", 32'(b_empty), 32'b11);
      check("mid_rst_cur", 32'(b_cur), 32'd0);
      check("mid_rst_full", 32'(b_full), 32'd0);
      b_wr = 1'b1; b_din = 8'h99;
      @(negedge ck);
      check("mid_w1_empty", 32'(b_empty), 32'b10);
      check("mid_w1_head", 32'(b_dout[7:0]), 32'h99);
      check("mid_w1_cur", 32'(b_cur), 32'd0);
      b_din = 8'h9A;
      @(negedge ck);
      check("mid_w2_cur", 32'(b_cur), 32'd0);
      b_din = 8'h9B;
      @(negedge ck);
      check("mid_w3_cur", 32'(b_cur), 32'd1);
      check("mid_w3_empty", 32'(b_empty), 32'b10);
      b_wr = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
